// File: rtl/board_port_arbiter.sv
// board_port_arbiter: shares the board storage port between the game state
// machine (reads and piece writes), the victory checker and the display
// scanner (reads). Grants are combinational from the req inputs. Accepted
// accesses are issued through a registered memory-side port one cycle
// later, and read results return tagged one cycle after that.
// Optional feature macro: BOARD_ARB_AGING_EN adds a display wait counter.
// When the display has waited MAX_WAIT cycles, it is promoted above the
// checker and above game reads.

module board_port_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    // game requester
    input  logic       g_req,
    input  logic       g_we,
    input  logic [2:0] g_row,
    input  logic [2:0] g_col,
    input  logic [1:0] g_wdata,
    output logic       g_gnt,
    // checker requester
    input  logic       c_req,
    input  logic [2:0] c_row,
    input  logic [2:0] c_col,
    output logic       c_gnt,
    // display requester
    input  logic       d_req,
    input  logic [2:0] d_row,
    input  logic [2:0] d_col,
    output logic       d_gnt,
    // board storage side
    output logic [2:0] mem_row,
    output logic [2:0] mem_col,
    output logic [1:0] mem_wdata,
    output logic       mem_write,
    input  logic [1:0] mem_rdata,
    // read return
    output logic       rd_valid,
    output logic [1:0] rd_data,
    output logic [1:0] rd_tag
);

    typedef enum logic [1:0] {
        TAG_GAME  = 2'b00,
        TAG_CHECK = 2'b01,
        TAG_DISP  = 2'b10
    } tag_e;

    // Last reader served. Used to break ties between checker and display.
    typedef enum logic {
        RR_CHECK = 1'b0,
        RR_DISP  = 1'b1
    } rr_e;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 1..15");
    end

    rr_e        rr;
    logic       disp_aged;
    logic       any_gnt;
    logic       game_write;
    logic [2:0] sel_row;
    logic [2:0] sel_col;
    tag_e       sel_tag;
    logic       iss_valid;
    tag_e       iss_tag;

`ifdef BOARD_ARB_AGING_EN
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    // Count the cycles the display has been refused. Saturate at 15 and clear when it is served or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!d_req || d_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign disp_aged = (wait_cnt >= WAIT_LIMIT);
`else
    assign disp_aged = 1'b0;
`endif

    // Grant selection: game writes first, then an aged display, then game reads, then checker/display round-robin.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        g_gnt = 1'b0;
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (g_req && g_we) begin
                g_gnt = 1'b1;
            end else if (d_req && disp_aged) begin
                d_gnt = 1'b1;
            end else if (g_req) begin
                g_gnt = 1'b1;
            end else if (c_req && d_req) begin
                if (rr == RR_CHECK) begin
                    d_gnt = 1'b1;
                end else begin
                    c_gnt = 1'b1;
                end
            end else if (c_req) begin
                c_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    assign any_gnt    = g_gnt | c_gnt | d_gnt;
    assign game_write = g_gnt & g_we;

    // Route the granted requester's address and tag toward the issue registers.
    always_comb begin
        sel_row = g_row;
        sel_col = g_col;
        sel_tag = TAG_GAME;
        if (c_gnt) begin
            sel_row = c_row;
            sel_col = c_col;
            sel_tag = TAG_CHECK;
        end else if (d_gnt) begin
            sel_row = d_row;
            sel_col = d_col;
            sel_tag = TAG_DISP;
        end
    end

    // Issue stage: capture the granted access and drive it to storage. Update the round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            mem_row   <= '0;
            mem_col   <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            iss_valid <= 1'b0;
            iss_tag   <= TAG_GAME;
            rr        <= RR_DISP;
        end else begin
            mem_write <= game_write;
            iss_valid <= any_gnt & ~game_write;
            if (any_gnt) begin
                mem_row <= sel_row;
                mem_col <= sel_col;
                iss_tag <= sel_tag;
            end
            if (game_write) begin
                mem_wdata <= g_wdata;
            end
            if (c_gnt) begin
                rr <= RR_CHECK;
            end else if (d_gnt) begin
                rr <= RR_DISP;
            end
        end
    end

    // Return stage: register storage read data for reads issued last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_tag   <= '0;
        end else begin
            rd_valid <= iss_valid;
            if (iss_valid) begin
                rd_data <= mem_rdata;
                rd_tag  <= iss_tag;
            end
        end
    end

endmodule

// File: tb/tb_board_port_arbiter.sv
// Directed bench for board_port_arbiter. It holds a small 8x8 board storage
// model behind the memory port. Inputs are driven 1 ns after the rising
// edge. Grants are sampled 1 ns later. Registered outputs are sampled
// 1 ns after each edge.

module tb_board_port_arbiter;

    logic       clk;
    logic       rst;
    logic       g_req, g_we;
    logic [2:0] g_row, g_col;
    logic [1:0] g_wdata;
    logic       g_gnt;
    logic       c_req;
    logic [2:0] c_row, c_col;
    logic       c_gnt;
    logic       d_req;
    logic [2:0] d_row, d_col;
    logic       d_gnt;
    logic [2:0] mem_row, mem_col;
    logic [1:0] mem_wdata;
    logic       mem_write;
    logic [1:0] mem_rdata;
    logic       rd_valid;
    logic [1:0] rd_data;
    logic [1:0] rd_tag;

    int passed = 0;
    int total  = 0;

    logic [1:0] board [8][8];

    board_port_arbiter #(.MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .g_req(g_req), .g_we(g_we), .g_row(g_row), .g_col(g_col),
        .g_wdata(g_wdata), .g_gnt(g_gnt),
        .c_req(c_req), .c_row(c_row), .c_col(c_col), .c_gnt(c_gnt),
        .d_req(d_req), .d_row(d_row), .d_col(d_col), .d_gnt(d_gnt),
        .mem_row(mem_row), .mem_col(mem_col), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_rdata(mem_rdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag(rd_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board storage model: written on the edge that ends a write-issue cycle. Read combinationally.
    always @(posedge clk) begin
        if (mem_write) board[mem_row][mem_col] <= mem_wdata;
    end
    assign mem_rdata = board[mem_row][mem_col];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        g_req = 1'b0; g_we = 1'b0; g_row = '0; g_col = '0; g_wdata = '0;
        c_req = 1'b0; c_row = '0; c_col = '0;
        d_req = 1'b0; d_row = '0; d_col = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        g_req = 1'b1; c_req = 1'b1; d_req = 1'b1;
        rst = 1'b1;
        #1;
        total++;
        if ({g_gnt, c_gnt, d_gnt} !== 3'b000)
            $display("FAIL reset_gnt: got %b want 000", {g_gnt, c_gnt, d_gnt});
        else passed++;
        tick();
        tick();
        total++;
        if ({rd_valid, mem_write, mem_row, mem_col, mem_wdata, rd_data, rd_tag} !== 15'd0)
            $display("FAIL reset_outputs: got rd_valid=%b mem_write=%b row=%0d col=%0d wdata=%b rd_data=%b rd_tag=%b want all zero",
                     rd_valid, mem_write, mem_row, mem_col, mem_wdata, rd_data, rd_tag);
        else passed++;
        total++;
        if ({g_gnt, c_gnt, d_gnt} !== 3'b000)
            $display("FAIL reset_gnt_held: got %b want 000", {g_gnt, c_gnt, d_gnt});
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if ({g_gnt, c_gnt, d_gnt} !== 3'b100)
            $display("FAIL first_grant_game: got %b want 100", {g_gnt, c_gnt, d_gnt});
        else passed++;
        total++;
        if ({rd_valid, mem_write} !== 2'b00)
            $display("FAIL post_reset_quiet: got rd_valid=%b mem_write=%b want 0 0", rd_valid, mem_write);
        else passed++;
        tick();
        idle_inputs();
        tick();
        tick();
        tick();
    endtask

    task automatic test_write_then_read();
        g_req = 1'b1; g_we = 1'b1; g_row = 3'd3; g_col = 3'd4; g_wdata = 2'b01;
        #1;
        total++;
        if ({g_gnt, c_gnt, d_gnt} !== 3'b100)
            $display("FAIL wr_gnt: got %b want 100", {g_gnt, c_gnt, d_gnt});
        else passed++;
        tick();
        total++;
        if ({mem_write, mem_row, mem_col, mem_wdata} !== {1'b1, 3'd3, 3'd4, 2'b01})
            $display("FAIL wr_issue: got write=%b row=%0d col=%0d wdata=%b want 1 3 4 01",
                     mem_write, mem_row, mem_col, mem_wdata);
        else passed++;
        g_we = 1'b0;
        #1;
        total++;
        if (g_gnt !== 1'b1)
            $display("FAIL rd_gnt: got %b want 1", g_gnt);
        else passed++;
        tick();
        idle_inputs();
        total++;
        if ({mem_write, rd_valid, mem_row, mem_col} !== {1'b0, 1'b0, 3'd3, 3'd4})
            $display("FAIL rd_issue: got write=%b rd_valid=%b row=%0d col=%0d want 0 0 3 4",
                     mem_write, rd_valid, mem_row, mem_col);
        else passed++;
        tick();
        total++;
        if ({rd_valid, rd_data, rd_tag} !== {1'b1, 2'b01, 2'b00})
            $display("FAIL rd_return: got valid=%b data=%b tag=%b want 1 01 00", rd_valid, rd_data, rd_tag);
        else passed++;
        tick();
        total++;
        if (rd_valid !== 1'b0)
            $display("FAIL rd_single: got rd_valid=%b want 0", rd_valid);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_gnt;
        logic [1:0] exp_tag;
        logic [1:0] exp_data;
        do_reset();
        // Preload (1,2)=10 and (5,6)=01 with game writes. Game grants do not move rr.
        g_req = 1'b1; g_we = 1'b1; g_row = 3'd1; g_col = 3'd2; g_wdata = 2'b10;
        tick();
        g_row = 3'd5; g_col = 3'd6; g_wdata = 2'b01;
        tick();
        idle_inputs();
        c_req = 1'b1; c_row = 3'd1; c_col = 3'd2;
        d_req = 1'b1; d_row = 3'd5; d_col = 3'd6;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                c_req = 1'b0;
                d_req = 1'b0;
            end
            #1;
            exp_gnt = (i >= 4) ? 3'b000 : ((i % 2 == 0) ? 3'b010 : 3'b001);
            total++;
            if ({g_gnt, c_gnt, d_gnt} !== exp_gnt)
                $display("FAIL rr_gnt[%0d]: got %b want %b", i, {g_gnt, c_gnt, d_gnt}, exp_gnt);
            else passed++;
            if (i >= 2) begin
                exp_tag  = (i % 2 == 0) ? 2'b01 : 2'b10;
                exp_data = (i % 2 == 0) ? 2'b10 : 2'b01;
                total++;
                if ({rd_valid, rd_tag, rd_data} !== {1'b1, exp_tag, exp_data})
                    $display("FAIL rr_return[%0d]: got valid=%b tag=%b data=%b want 1 %b %b",
                             i, rd_valid, rd_tag, rd_data, exp_tag, exp_data);
                else passed++;
            end else begin
                total++;
                if (rd_valid !== 1'b0)
                    $display("FAIL rr_no_return[%0d]: got rd_valid=%b want 0", i, rd_valid);
                else passed++;
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_game_priority();
        idle_inputs();
        g_req = 1'b1; g_we = 1'b1; g_row = 3'd7; g_col = 3'd7; g_wdata = 2'b10;
        c_req = 1'b1; c_row = 3'd7; c_col = 3'd7;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) g_req = 1'b0;
            if (i == 4) c_req = 1'b0;
            #1;
            if (i < 4) begin
                total++;
                if ({g_gnt, c_gnt, d_gnt} !== ((i < 3) ? 3'b100 : 3'b010))
                    $display("FAIL prio_gnt[%0d]: got %b want %b", i, {g_gnt, c_gnt, d_gnt},
                             (i < 3) ? 3'b100 : 3'b010);
                else passed++;
            end
            if (i >= 1) begin
                total++;
                if (mem_write !== ((i <= 3) ? 1'b1 : 1'b0))
                    $display("FAIL prio_write[%0d]: got %b want %b", i, mem_write, (i <= 3) ? 1'b1 : 1'b0);
                else passed++;
            end
            tick();
        end
        total++;
        if ({rd_valid, rd_tag, rd_data} !== {1'b1, 2'b01, 2'b10})
            $display("FAIL prio_return: got valid=%b tag=%b data=%b want 1 01 10", rd_valid, rd_tag, rd_data);
        else passed++;
        tick();
    endtask

    task automatic test_display_wait();
        idle_inputs();
        g_req = 1'b1; g_we = 1'b0; g_row = 3'd3; g_col = 3'd4;
        c_req = 1'b1; c_row = 3'd1; c_col = 3'd2;
        d_req = 1'b1; d_row = 3'd5; d_col = 3'd6;
`ifdef BOARD_ARB_AGING_EN
        // Counter is i in cycle i. It reaches MAX_WAIT=8 in cycle 8.
        for (int i = 0; i < 9; i++) begin
            #1;
            total++;
            if ({g_gnt, c_gnt, d_gnt} !== ((i == 8) ? 3'b001 : 3'b100))
                $display("FAIL aging_gnt[%0d]: got %b want %b", i, {g_gnt, c_gnt, d_gnt},
                         (i == 8) ? 3'b001 : 3'b100);
            else passed++;
            tick();
        end
`else
        for (int i = 0; i < 12; i++) begin
            #1;
            total++;
            if ({g_gnt, c_gnt, d_gnt} !== 3'b100)
                $display("FAIL starve_gnt[%0d]: got %b want 100", i, {g_gnt, c_gnt, d_gnt});
            else passed++;
            tick();
        end
`endif
        idle_inputs();
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_read();
        idle_inputs();
        c_req = 1'b1; c_row = 3'd1; c_col = 3'd2;
        #1;
        total++;
        if (c_gnt !== 1'b1)
            $display("FAIL midrst_gnt: got %b want 1", c_gnt);
        else passed++;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({rd_valid, rd_data, mem_write} !== 4'b0000)
                $display("FAIL midrst_quiet[%0d]: got valid=%b data=%b write=%b want 0 00 0",
                         i, rd_valid, rd_data, mem_write);
            else passed++;
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_write_then_read();
        test_round_robin();
        test_game_priority();
        test_display_wait();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
